// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states, mux selects, ALU codes.
// Pure declarations; no timing or flow control of its own.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    logic       supported;
    logic       arith;
    logic [1:0] ctl;
  } alu_dec_t;

  // Unsupported commands fall back to ADD with supported=0 so writes and flags are suppressed.
  function automatic alu_dec_t decode_cmd(input logic [3:0] cmd);
    alu_dec_t d;
    d.supported = 1'b1;
    d.arith     = 1'b0;
    d.ctl       = ALU_ADD;
    case (cmd)
      CMD_ADD: d.arith = 1'b1;
      CMD_SUB: begin
        d.ctl   = ALU_SUB;
        d.arith = 1'b1;
      end
      CMD_AND: d.ctl = ALU_AND;
      CMD_ORR: d.ctl = ALU_ORR;
      default: d.supported = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_mc_condcheck.sv
// ARM condition-code evaluator over {N,Z,C,V}; 4'hF (NV) evaluates false.
// Purely combinational, zero latency, no flow control.
module arm_mc_condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  logic base;

  assign {n, z, c, v} = flags;

  // Even codes are the base test; odd codes below AL are its inverse.
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
  end

  assign cond_ex = (cond == 4'hF) ? 1'b0 : (base ^ (cond[0] & (cond[3:1] != 3'd7)));

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/exec/mem/writeback, drives all enables and selects.
// Outputs decode from current state; FETCH/MEMRD/MEMWR stall while MemReady is low (unless MEM_WAIT_EN=0).
module arm_mc_ctrl
  import arm_mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit COND_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state_o
);

  state_t   state_q;
  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic     cond_ex_q;
  logic     mem_rdy;
  logic     cond_raw;
  logic     cond_ex;
  alu_dec_t alu_dec;

  logic pc_wr, ir_wr, reg_wr, mem_wr;

  assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;
  assign alu_dec = decode_cmd(Funct[4:1]);

  arm_mc_condcheck u_condcheck (
    .cond    (Cond),
    .flags   ({nz_q, cv_q}),
    .cond_ex (cond_raw)
  );

  assign cond_ex = COND_EN ? cond_raw : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      nz_q      <= 2'b00;
      cv_q      <= 2'b00;
      cond_ex_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (mem_rdy) state_q <= DECODE;
        DECODE: begin
          cond_ex_q <= cond_ex;
          case (Op)
            OP_MEM:  state_q <= MEMADR;
            OP_BR:   state_q <= BRANCH;
            OP_DP:   state_q <= Funct[5] ? EXECI : EXECR;
            default: state_q <= FETCH;
          endcase
        end
        MEMADR: state_q <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:  if (mem_rdy) state_q <= MEMWB;
        MEMWB:  state_q <= FETCH;
        MEMWR:  if (mem_rdy) state_q <= FETCH;
        EXECR, EXECI: begin
          state_q <= ALUWB;
          // Flags land after DECODE has already latched this instruction's condition.
          if (cond_ex_q && Funct[0] && alu_dec.supported) begin
            nz_q <= ALUFlags[3:2];
            if (alu_dec.arith) cv_q <= ALUFlags[1:0];
          end
        end
        ALUWB:   state_q <= FETCH;
        BRANCH:  state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_wr     = mem_rdy;
        pc_wr     = mem_rdy;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      MEMADR: ALUSrcB = SRCB_IMM;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_wr    = cond_ex_q;
        pc_wr     = cond_ex_q && (Rd == 4'hF);
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_wr = cond_ex_q;
      end
      EXECR: ALUControl = alu_dec.ctl;
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec.ctl;
      end
      ALUWB: begin
        reg_wr = cond_ex_q && alu_dec.supported;
        pc_wr  = cond_ex_q && alu_dec.supported && (Rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_wr     = cond_ex_q;
      end
      default: ;
    endcase
  end

  // Reset gates the enables combinationally so nothing can pulse while reset is held.
  assign PCWrite  = pc_wr  & reset;
  assign IRWrite  = ir_wr  & reset;
  assign RegWrite = reg_wr & reset;
  assign MemWrite = mem_wr & reset;

  assign RegSrc  = {(Op == OP_MEM) && !Funct[0], Op == OP_BR};
  assign ImmSrc  = Op;
  assign state_o = state_q;

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Scoreboarded random/directed bench for arm_mc_ctrl against a per-instruction phase model.
module tb_arm_mc_ctrl;
  import arm_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl;
  logic [3:0] state_o;

  arm_mc_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state_o(state_o)
  );

  // Second instance: no wait-state handshake, MemReady tied low, looping ADD R1,R2,#5.
  logic       rst2;
  logic [3:0] cond2 = 4'hE;
  logic [1:0] op2 = 2'b00;
  logic [5:0] funct2 = 6'h28;
  logic [3:0] rd2 = 4'h1;
  logic [3:0] flags2 = 4'h0;
  logic       mrdy2 = 1'b0;
  logic       pcw2, irw2, rw2, mw2, adr2, srca2;
  logic [1:0] srcb2, res2, regsrc2, immsrc2, aluc2;
  logic [3:0] state2;
  bit         done2 = 1'b0;

  arm_mc_ctrl #(.MEM_WAIT_EN(1'b0)) dut2 (
    .clk(clk), .reset(rst2), .Cond(cond2), .Op(op2), .Funct(funct2), .Rd(rd2),
    .ALUFlags(flags2), .MemReady(mrdy2),
    .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2),
    .AdrSrc(adr2), .ALUSrcA(srca2), .ALUSrcB(srcb2), .ResultSrc(res2),
    .RegSrc(regsrc2), .ImmSrc(immsrc2), .ALUControl(aluc2), .state_o(state2)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr, srca;
    logic [1:0] srcb, res, aluc, regsrc, immsrc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state: architectural flags and the instruction in flight.
  logic       mn = 0, mz = 0, mc = 0, mv = 0;
  logic [3:0] cur_cond;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  logic [3:0] cur_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic cond_true(input logic [3:0] c);
    case (c)
      4'h0: return mz;
      4'h1: return !mz;
      4'h2: return mc;
      4'h3: return !mc;
      4'h4: return mn;
      4'h5: return !mn;
      4'h6: return mv;
      4'h7: return !mv;
      4'h8: return mc && !mz;
      4'h9: return !mc || mz;
      4'hA: return mn == mv;
      4'hB: return mn != mv;
      4'hC: return !mz && (mn == mv);
      4'hD: return mz || (mn != mv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {supported, alu control}
  function automatic logic [2:0] alu_model(input logic [3:0] cmd);
    case (cmd)
      4'd4:  return {1'b1, 2'b00};
      4'd2:  return {1'b1, 2'b01};
      4'd0:  return {1'b1, 2'b10};
      4'd12: return {1'b1, 2'b11};
      default: return {1'b0, 2'b00};
    endcase
  endfunction

  function automatic exp_t mkexp(input state_t s, input logic mr, input logic cnd);
    exp_t e;
    logic [2:0] a;
    a = alu_model(cur_funct[4:1]);
    e = '0;
    e.st     = s;
    e.regsrc = {(cur_op == 2'b01) && !cur_funct[0], cur_op == 2'b10};
    e.immsrc = cur_op;
    case (s)
      FETCH:  begin e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
      DECODE: begin e.srca = 1; e.srcb = 2'b10; end
      MEMADR: e.srcb = 2'b01;
      MEMRD:  e.adr = 1;
      MEMWB:  begin e.res = 2'b01; e.rw = cnd; e.pcw = cnd && (cur_rd == 4'hF); end
      MEMWR:  begin e.adr = 1; e.mw = cnd; end
      EXECR:  e.aluc = a[1:0];
      EXECI:  begin e.srcb = 2'b01; e.aluc = a[1:0]; end
      ALUWB:  begin e.rw = cnd && a[2]; e.pcw = cnd && a[2] && (cur_rd == 4'hF); end
      BRANCH: begin e.srcb = 2'b01; e.res = 2'b10; e.pcw = cnd; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input state_t s, input logic mr, input logic cnd, input logic [3:0] af);
    @(posedge clk);
    #1;
    Cond = cur_cond; Op = cur_op; Funct = cur_funct; Rd = cur_rd;
    MemReady = mr;
    ALUFlags = af;
    exp_q.push_back(mkexp(s, mr, cnd));
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input bit force_af, input logic [3:0] faf, input bit abort);
    logic       cnd;
    logic [2:0] a;
    logic [3:0] af;
    cur_cond = ins[31:28]; cur_op = ins[27:26]; cur_funct = ins[25:20]; cur_rd = ins[15:12];
    for (int i = 0; i < fw; i++) step(FETCH, 1'b0, 1'b0, rnd4());
    step(FETCH, 1'b1, 1'b0, rnd4());
    cnd = cond_true(cur_cond);
    step(DECODE, rnd1(), cnd, rnd4());
    case (cur_op)
      2'b00: begin
        af = force_af ? faf : rnd4();
        step(cur_funct[5] ? EXECI : EXECR, rnd1(), cnd, af);
        a = alu_model(cur_funct[4:1]);
        if (cnd && cur_funct[0] && a[2]) begin
          mn = af[3]; mz = af[2];
          if (a[1:0] == 2'b00 || a[1:0] == 2'b01) begin mc = af[1]; mv = af[0]; end
        end
        step(ALUWB, rnd1(), cnd, rnd4());
      end
      2'b01: begin
        step(MEMADR, rnd1(), cnd, rnd4());
        if (cur_funct[0]) begin
          for (int i = 0; i < mw; i++) step(MEMRD, 1'b0, cnd, rnd4());
          step(MEMRD, 1'b1, cnd, rnd4());
          step(MEMWB, rnd1(), cnd, rnd4());
        end else begin
          for (int i = 0; i < mw; i++) step(MEMWR, 1'b0, cnd, rnd4());
          if (abort) begin
            step(MEMWR, 1'b0, cnd, rnd4());
            @(negedge clk);
            #1 reset = 1'b0;
            #1;
            chk("abort MemWrite", 32'(MemWrite), 32'd0);
            chk("abort state", 32'(state_o), 32'(FETCH));
            chk("abort enables", 32'({PCWrite, IRWrite, RegWrite}), 32'd0);
            MemReady = 1'b0;
            #2 reset = 1'b1;
            mn = 0; mz = 0; mc = 0; mv = 0;
          end else begin
            step(MEMWR, 1'b1, cnd, rnd4());
          end
        end
      end
      2'b10: step(BRANCH, rnd1(), cnd, rnd4());
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    logic [3:0] cmds [4];
    cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      w[27:26] = 2'b00;
    else if (k < 7) w[27:26] = 2'b01;
    else if (k < 9) w[27:26] = 2'b10;
    else            w[27:26] = 2'b11;
    if (w[27:26] == 2'b00 && $urandom_range(0, 3) != 0) w[24:21] = cmds[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
    if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
    return w;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (reset && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.st = state_o; a.pcw = PCWrite; a.irw = IRWrite; a.rw = RegWrite; a.mw = MemWrite;
      a.adr = AdrSrc; a.srca = ALUSrcA; a.srcb = ALUSrcB; a.res = ResultSrc;
      a.aluc = ALUControl; a.regsrc = RegSrc; a.immsrc = ImmSrc;
      cyc++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace cycle %0d: got {st,en,sel}=%h, expected %h (state got %0d exp %0d)",
                 cyc, a, e, a.st, e.st);
      end
    end
  end

  initial begin : no_wait_check
    logic [3:0] seq [4];
    seq[0] = FETCH; seq[1] = DECODE; seq[2] = EXECI; seq[3] = ALUWB;
    rst2 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("nowait state", 32'(state2), 32'(seq[i % 4]));
      chk("nowait RegWrite", 32'(rw2), 32'(i % 4 == 3));
      chk("nowait PCWrite", 32'(pcw2), 32'(i % 4 == 0));
    end
    done2 = 1'b1;
  end

  initial begin
    reset = 1'b0;
    MemReady = 1'b1;
    ALUFlags = 4'h0;
    Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0;
    @(posedge clk);
    #1;
    chk("reset state", 32'(state_o), 32'(FETCH));
    chk("reset enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    chk("reset selects", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_1_10_10);
    MemReady = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;

    run_instr(32'hE2821005, 0, 0, 0, 4'h0, 0);   // ADD R1,R2,#5
    run_instr(32'hE5910000, 0, 2, 0, 4'h0, 0);   // LDR R0,[R1], two wait cycles
    run_instr(32'hE5810000, 0, 1, 0, 4'h0, 0);   // STR R0,[R1], one wait cycle
    run_instr(32'hE0500000, 1, 0, 1, 4'b0110, 0); // SUBS R0,R0,R0 -> Z=1
    run_instr(32'h1AFFFFFE, 0, 0, 0, 4'h0, 0);   // BNE: not taken
    run_instr(32'hE0500000, 0, 0, 1, 4'b0110, 0);
    run_instr(32'h0AFFFFFE, 0, 0, 0, 4'h0, 0);   // BEQ: taken

    repeat (200) run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 0, 4'h0, 0);

    run_instr(32'hE0500000, 0, 0, 1, 4'b0100, 0);
    run_instr(32'hE5810000, 0, 1, 0, 4'h0, 1);   // STR aborted by reset in MEMWR
    run_instr(32'h1AFFFFFE, 0, 0, 0, 4'h0, 0);   // flags cleared: BNE taken
    run_instr(32'h0AFFFFFE, 0, 0, 0, 4'h0, 0);

    repeat (50) run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 0, 4'h0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 200 && !done2; i++) @(posedge clk);
    chk("nowait checker done", 32'(done2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_mc_ctrl.md
# arm_mc_ctrl

Multicycle control unit for the ARM-subset core, replacing the single-cycle controller behind `arm`. It sequences each instruction through fetch, decode, execute, memory and writeback states, and issues every datapath enable and mux select. It holds the condition flags and latches the condition result. A parameterised memory-ready handshake lets the core run against either zero-wait or wait-state instruction/data memory.

## Interface
- `MEM_WAIT_EN`, default 1: when 1, honour `MemReady`; when 0, treat `MemReady` as constantly 1.
- `COND_EN`, default 1: when 1, evaluate `Cond`; when 0, every instruction executes as if `Cond`=AL (4'hE).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Cond`  in  4  Instr[31:28].
- `Op`  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `Funct`  in  6  Instr[25:20]: I bit, cmd[3:0], S/L bit.
- `Rd`  in  4  Instr[15:12].
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU, valid in execute states.
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`  out  1 each  write enables.
- `AdrSrc`  out  1  selects the memory address: 0 = PC, 1 = ALUOut.
- `ALUSrcA`  out  1  selects ALU operand A: 0 = Rn, 1 = PC.
- `ALUSrcB`  out  2  selects ALU operand B: 00 = Rm/WriteData, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  selects the result: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `RegSrc`  out  2  [0] = read R15 as Rn (branch); [1] = read Rd as second operand (STR).
- `ImmSrc`  out  2  equals `Op`.
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- `state_o`  out  4  current state, for debug.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- **FETCH:** AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in the cycle where `MemReady`=1; that cycle moves to DECODE.
  - Otherwise the FSM stays in FETCH.
- **DECODE:** ALUSrcA=1, ALUSrcB=10 (forms PC+8); cond_ex_q latches at the end of this cycle. Next state by `Op`:
  - `Op`=01 → MEMADR.
  - `Op`=10 → BRANCH.
  - `Op`=00 with `Funct`[5]=1 → EXECI; with `Funct`[5]=0 → EXECR.
  - `Op`=11 → FETCH, with no side effects.
- **Memory path:**
  - MEMADR: ALUSrcB=01, ADD. `Funct`[0]=1 → MEMRD; `Funct`[0]=0 → MEMWR.
  - MEMRD: AdrSrc=1. Stays until `MemReady`, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=cond_ex_q, then → FETCH.
  - MEMWR: AdrSrc=1, MemWrite=cond_ex_q held for the whole state. Leaves to FETCH on `MemReady`.
- **EXECR / EXECI:** ALUSrcB=00 for EXECR, 01 for EXECI; ALU decode is active; next state ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=cond_ex_q and opcode supported, then → FETCH.
- **BRANCH:** ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_ex_q, then → FETCH.
- **PC writeback:** when `Rd`=15 and the instruction writes a register, PCWrite is also asserted in MEMWB/ALUWB, gated by cond_ex_q.
- **ALU decode** (only in EXEC states; ADD elsewhere) from cmd=`Funct`[4:1]:
  - 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR.
  - Any other cmd: ALUControl=ADD, RegWrite suppressed, no flag write.
- **Flags:** registers nz_q and cv_q are written at the end of EXECR/EXECI when cond_ex_q=1 and S=`Funct`[0]=1.
  - nz_q is updated for all supported opcodes.
  - cv_q is updated only for ADD/SUB.
- **Condition evaluation:** the condition is computed from the flag registers during DECODE, covering all 15 ARM conditions; 4'hF evaluates false.
  - Because of the DECODE latch, a flag update in EXEC never affects the same instruction's writeback.

## Timing
- **Reset** (`reset`=0, asynchronous): state=FETCH, flags=0, cond_ex_q=0. All write enables are forced to 0 while reset is low; mux selects take FETCH values.
- **First fetch:** occurs on the first rising edge after deassertion with `MemReady`=1.
- **Cycles per instruction with zero-wait memory:**
  - Data-processing: 4 (FETCH, DECODE, EXEC, ALUWB).
  - Branch: 3.
  - LDR: 5.
  - STR: 4.
  - Each wait cycle (`MemReady`=0 in FETCH, MEMRD or MEMWR) adds 1.
- **Wait states:** during a wait, outputs hold their state values and the FSM stays put.
- **MEM_WAIT_EN=0:** `MemReady` is ignored.
- **Reset mid-instruction:** aborts immediately. No write enable may glitch high during or after reset; the next fetch starts clean.
- **Output decode:** all outputs are Moore (a function of state, cond_ex_q, `Funct` and `Rd`), except IRWrite/PCWrite in FETCH, which also depend on `MemReady`.

## Structure
- Package `arm_mc_pkg` holds:
  - enum `state_t`, 4 bits;
  - localparams for ALUControl codes;
  - localparams for the ALUSrcB/ResultSrc encodings;
  - localparams for the Op encodings.
- Sub-module `arm_mc_condcheck` (combinational): inputs `Cond` and {N,Z,C,V}; output cond_ex. It is bypassed when `COND_EN`=0.

## Test plan
- **ADD R1,R2,#5** (0xE2821005), `MemReady`=1: state sequence FETCH→DECODE→EXECI→ALUWB, with RegWrite=1 only in cycle 4 and PCWrite=1 only in cycle 1.
- **LDR R0,[R1]** (0xE5910000), `MemReady` held 0 for 2 cycles in MEMRD: MEMRD lasts 3 cycles, RegWrite=1 in MEMWB, 7 cycles total.
- **STR R0,[R1]** (0xE5810000), `MemReady`=0 for 1 cycle in MEMWR: MemWrite is high for exactly 2 cycles and RegSrc[1]=1.
- **SUBS R0,R0,R0 then BNE** (0x1AFFFFFE): Z=1 is captured, so the branch's PCWrite stays 0. **BEQ** (0x0AFFFFFE) after the same SUBS: PCWrite=1 in BRANCH.
- **Reset mid-MEMWR:** pulse `reset` low for 3 ns between edges. MemWrite drops to 0 asynchronously, state_o=FETCH, and flags are cleared.
- **`MEM_WAIT_EN`=0** with `MemReady` tied 0: ADD still completes in 4 cycles.
